// File: rtl/inpass4_sync_filter.sv
// inpass4_sync_filter: four pad-to-fabric input channels. Each channel can be a
// combinational bypass, a single register, a 2-flop synchronizer, or a
// synchronizer followed by a debounce filter. Each channel also drives a
// one-cycle change pulse. All per-channel flops run in every mode; the mode
// only chooses which of them is driven onto O_n.
module inpass4_sync_filter #(
  parameter int unsigned NoConfigBits = 8,
  parameter int unsigned FILTER_CNT   = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    UserCLK,
  input  logic                    UserRST,
  input  logic                    I0,
  input  logic                    I1,
  input  logic                    I2,
  input  logic                    I3,
  output logic                    O0,
  output logic                    O1,
  output logic                    O2,
  output logic                    O3,
  output logic                    E0,
  output logic                    E1,
  output logic                    E2,
  output logic                    E3,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned MODE_W = 2;

  // Filter terminal count: the mismatch that brings the counter here commits.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_REG    = 2'b01,
    MODE_SYNC   = 2'b10,
    MODE_FILT   = 2'b11
  } mode_e;

  logic [NCH-1:0] in_c;
  logic [NCH-1:0] o_c;
  logic [NCH-1:0] e_c;

  assign in_c = {I3, I2, I1, I0};

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    mode_e            mode_c;
    logic             sel_c;
    logic             chg_c;

    logic             r_q,    r_d;
    logic             s1_q,   s1_d;
    logic             s2_q,   s2_d;
    logic             f_q,    f_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    assign mode_c = mode_e'(ConfigBits[MODE_W*n +: MODE_W]);

    // Output select: pick the stage matching this channel's mode.
    always_comb begin
      sel_c = in_c[n];
      unique case (mode_c)
        MODE_BYPASS: sel_c = in_c[n];
        MODE_REG:    sel_c = r_q;
        MODE_SYNC:   sel_c = s2_q;
        MODE_FILT:   sel_c = f_q;
        default:     sel_c = in_c[n];
      endcase
    end

    // Change pulse: selected value differs from last cycle's selection.
    always_comb begin
      chg_c = 1'b0;
      if (mode_c != MODE_BYPASS) begin
        chg_c = (sel_c != prev_q);
      end
    end

    // Next state: capture, synchronizer chain, debounce filter, history.
    always_comb begin
      r_d    = in_c[n];
      s1_d   = in_c[n];
      s2_d   = s1_q;
      prev_d = sel_c;
      f_d    = f_q;
      cnt_d  = cnt_q;
      if (s2_q == f_q) begin
        cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_LAST) begin
        f_d   = s2_q;
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    // Channel registers with synchronous reset to all zeros.
    always_ff @(posedge UserCLK) begin
      if (UserRST) begin
        r_q    <= 1'b0;
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        f_q    <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= CNT_ZERO;
      end else begin
        r_q    <= r_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        f_q    <= f_d;
        prev_q <= prev_d;
        cnt_q  <= cnt_d;
      end
    end

    assign o_c[n] = sel_c;
    assign e_c[n] = chg_c;
  end

  assign O0 = o_c[0];
  assign O1 = o_c[1];
  assign O2 = o_c[2];
  assign O3 = o_c[3];
  assign E0 = e_c[0];
  assign E1 = e_c[1];
  assign E2 = e_c[2];
  assign E3 = e_c[3];

endmodule

// File: tb/tb_inpass4_sync_filter.sv
// Bench for inpass4_sync_filter: two builds (FILTER_CNT=4 and FILTER_CNT=1)
// driven with the same stimulus, each compared every cycle to a history-based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_inpass4_sync_filter;

  localparam int unsigned F_A = 4;
  localparam int unsigned F_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_v;
  logic [7:0] cfg;
  logic [3:0] oa, ea, ob, eb;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  inpass4_sync_filter #(.NoConfigBits(8), .FILTER_CNT(F_A), .CNT_W(8)) u_dut_a (
    .UserCLK(clk), .UserRST(rst),
    .I0(in_v[0]), .I1(in_v[1]), .I2(in_v[2]), .I3(in_v[3]),
    .O0(oa[0]), .O1(oa[1]), .O2(oa[2]), .O3(oa[3]),
    .E0(ea[0]), .E1(ea[1]), .E2(ea[2]), .E3(ea[3]),
    .ConfigBits(cfg)
  );

  inpass4_sync_filter #(.NoConfigBits(8), .FILTER_CNT(F_B), .CNT_W(8)) u_dut_b (
    .UserCLK(clk), .UserRST(rst),
    .I0(in_v[0]), .I1(in_v[1]), .I2(in_v[2]), .I3(in_v[3]),
    .O0(ob[0]), .O1(ob[1]), .O2(ob[2]), .O3(ob[3]),
    .E0(eb[0]), .E1(eb[1]), .E2(eb[2]), .E3(eb[3]),
    .ConfigBits(cfg)
  );

  // Reference model, index k = build*4 + channel. Histories hold the values
  // sampled since the last reset, newest in bit 0; anything older reads as 0.
  logic [63:0] hist_m [8];
  int          hcnt_m [8];
  logic [63:0] s2h_m  [8];
  int          scnt_m [8];
  logic        f_m    [8];
  logic        prev_m [8];

  function automatic logic sel_m(int k);
    int         ch;
    logic [1:0] md;
    ch = k % 4;
    md = cfg[2*ch +: 2];
    case (md)
      2'd0:    return in_v[ch];
      2'd1:    return (hcnt_m[k] >= 1) ? hist_m[k][0] : 1'b0;
      2'd2:    return (hcnt_m[k] >= 2) ? hist_m[k][1] : 1'b0;
      default: return f_m[k];
    endcase
  endfunction

  // Advance the model across one clock edge using the inputs held before it.
  task automatic model_edge();
    int   fc;
    logic s2pre;
    logic all_diff;
    for (int k = 0; k < 8; k++) begin
      fc = (k < 4) ? int'(F_A) : int'(F_B);
      if (rst) begin
        hist_m[k] = '0; hcnt_m[k] = 0;
        s2h_m[k]  = '0; scnt_m[k] = 0;
        f_m[k]    = 1'b0;
        prev_m[k] = 1'b0;
      end else begin
        prev_m[k] = sel_m(k);
        s2pre     = (hcnt_m[k] >= 2) ? hist_m[k][1] : 1'b0;
        s2h_m[k]  = {s2h_m[k][62:0], s2pre};
        scnt_m[k] = scnt_m[k] + 1;
        // Filtered value flips once the last fc synchronized samples all disagree.
        if (scnt_m[k] >= fc) begin
          all_diff = 1'b1;
          for (int j = 0; j < fc; j++) begin
            if (s2h_m[k][j] == f_m[k]) all_diff = 1'b0;
          end
          if (all_diff) f_m[k] = ~f_m[k];
        end
        hist_m[k] = {hist_m[k][62:0], in_v[k % 4]};
        hcnt_m[k] = hcnt_m[k] + 1;
      end
    end
  endtask

  task automatic model_out(input int b, output logic [3:0] o, output logic [3:0] e);
    logic s;
    for (int ch = 0; ch < 4; ch++) begin
      s     = sel_m(b*4 + ch);
      o[ch] = s;
      e[ch] = (cfg[2*ch +: 2] != 2'b00) && (s != prev_m[b*4 + ch]);
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // One clock: update model at the edge, compare both builds mid-cycle.
  task automatic step();
    logic [3:0] mo, me;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_out(0, mo, me);
    check("model_O_f4", oa, mo);
    check("model_E_f4", ea, me);
    model_out(1, mo, me);
    check("model_O_f1", ob, mo);
    check("model_E_f1", eb, me);
  endtask

  int e_hits;

  initial begin
    rst  = 1'b1;
    cfg  = 8'h00;
    in_v = 4'b1010;

    // Bypass under reset, then registered modes held at zero by reset.
    step();
    check("rst_bypass_O", oa, 4'b1010);
    check("rst_bypass_E", ea, 4'b0000);
    cfg = 8'b11_10_01_01;
    step();
    check("rst_modes_O", oa, 4'b0000);
    check("rst_modes_E", ea, 4'b0000);
    check("rst_modes_O_f1", ob, 4'b0000);

    // Latency: ch0..ch3 in modes 00/01/10/11, step all inputs 0 -> 1.
    in_v = 4'b0000;
    cfg  = 8'b11_10_01_00;
    step();
    rst = 1'b0;
    repeat (6) step();
    in_v = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step();
      check("lat_O_f4", oa, {k >= 5, k >= 1, 1'b1, 1'b1});
      check("lat_E_f4", ea, {k == 5, k == 1, k == 0, 1'b0});
      check("lat_O_f1", ob, {k >= 2, k >= 1, 1'b1, 1'b1});
      check("lat_E_f1", eb, {k == 2, k == 1, k == 0, 1'b0});
    end

    // Glitch rejection on ch0 in filter mode: 3-cycle pulse is swallowed.
    cfg  = 8'hFF;
    in_v = 4'b0000;
    repeat (10) step();
    in_v[0] = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) in_v[0] = 1'b0;
      step();
      check("glitch3_O0", {3'b000, oa[0]}, 4'b0000);
      check("glitch3_E0", {3'b000, ea[0]}, 4'b0000);
    end
    // A 4-cycle pulse passes, delayed, and both edges pulse E0.
    in_v[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 3) in_v[0] = 1'b0;
      check("pulse4_O0", {3'b000, oa[0]}, {3'b000, (k >= 5 && k <= 8)});
      check("pulse4_E0", {3'b000, ea[0]}, {3'b000, (k == 5 || k == 9)});
    end

    // Reset while ch3's filter is mid-count discards the count.
    in_v[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst_pre_O3", {3'b000, oa[3]}, 4'b0000);
    end
    rst = 1'b1;
    repeat (2) begin
      step();
      check("midrst_in_O3", {3'b000, oa[3]}, 4'b0000);
      check("midrst_in_E3", {3'b000, ea[3]}, 4'b0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("midrst_post_O3", {3'b000, oa[3]}, {3'b000, k >= 5});
    end

    // Runtime reconfig of ch1: 00 -> 01 with a steady 1 gives no pulse.
    cfg     = 8'b11_11_00_11;
    in_v[1] = 1'b1;
    repeat (10) step();
    cfg = 8'b11_11_01_11;
    for (int k = 0; k < 3; k++) begin
      step();
      check("reconf_O1", {3'b000, oa[1]}, 4'b0001);
      check("reconf_E1", {3'b000, ea[1]}, 4'b0000);
    end
    // Toggle I1 while moving to mode 10: exactly one pulse follows.
    in_v[1] = 1'b0;
    cfg     = 8'b11_11_10_11;
    e_hits  = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ea[1]) e_hits++;
    end
    check("reconf_E1_count", 4'(e_hits), 4'd1);

    // FILTER_CNT=1 build, ch2 filter mode, I2 toggling every 2 cycles.
    cfg  = 8'hFF;
    in_v = 4'b0000;
    repeat (6) step();
    for (int k = 0; k < 12; k++) begin
      in_v[2] = 1'((k / 2) % 2);
      step();
      check("f1_O2", {3'b000, ob[2]}, {3'b000, (k >= 2) && (((k - 2) / 2) % 2 == 1)});
      check("f1_E2", {3'b000, eb[2]}, {3'b000, (k >= 4) && (k % 2 == 0)});
    end

    // Randomized stress: slow and fast input activity, reconfig, resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) cfg = 8'($urandom);
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else     rst = ($urandom_range(0, 249) == 0);
      for (int ch = 0; ch < 4; ch++) begin
        if (((k / 500) % 2) == 0) begin
          if ($urandom_range(0, 9) == 0) in_v[ch] = ~in_v[ch];
        end else begin
          if ($urandom_range(0, 1) == 0) in_v[ch] = ~in_v[ch];
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/inpass4_sync_filter.md
Name: inpass4_sync_filter

Overview:
- External-to-fabric counterpart of the existing fabric-to-pad output pass BEL in the RAM_IO tile.
- Takes 4 pad-side inputs (EXTERNAL) and drives 4 fabric-side outputs into the switch matrix.
- Each channel is configured independently as one of: combinational bypass, single register, 2-flop synchronizer, or synchronizer plus debounce filter.
- Each channel also drives a one-cycle change-pulse output to the fabric.

Parameters:
- NoConfigBits, 8, width of ConfigBits: 2 bits per channel; fixed at 8.
- FILTER_CNT, 4, consecutive stable cycles required before the filtered output changes; legal range 1..255.
- CNT_W, 8, width of the per-channel debounce counter; must be >= clog2(FILTER_CNT+1).

Ports:
- UserCLK  input  1  user clock; EXTERNAL, SHARED_PORT.
- UserRST  input  1  synchronous active-high reset; EXTERNAL, SHARED_PORT.
- I0..I3  input  1 each  pad-side inputs; EXTERNAL; asynchronous to UserCLK in modes 10/11.
- O0..O3  output  1 each  fabric-side data outputs to the switch matrix.
- E0..E3  output  1 each  change pulse per channel to the switch matrix.
- ConfigBits  input  NoConfigBits  GLOBAL; channel n mode = ConfigBits[2n+1:2n].

Behaviour:
- Clocking and reset: one clock, UserCLK. Reset UserRST is synchronous, active-high.
  - UserRST clears all flops to 0: r_n, s1_n, s2_n, f_n, cnt_n, prev_n.
- Per-channel flops, updated every cycle in all modes; mode only selects which one is output:
  - r_n <= I_n
  - s1_n <= I_n; s2_n <= s1_n
  - f_n is the filter output; cnt_n is the filter counter; prev_n <= sel_n.
- Output select sel_n:
  - mode 00: I_n (combinational).
  - mode 01: r_n.
  - mode 10: s2_n.
  - mode 11: f_n.
  - O_n = sel_n.
- Latency, measured from the first UserCLK edge that samples a new I_n value (edge t0):
  - mode 00: 0 cycles; O follows I combinationally, including during reset.
  - mode 01: O updates at t0.
  - mode 10: O updates at t0+1.
  - mode 11: O updates at t0+1+FILTER_CNT.
- Filter, evaluated each edge when not in reset:
  - if s2_n == f_n: cnt_n <= 0.
  - else if cnt_n == FILTER_CNT-1: f_n <= s2_n, cnt_n <= 0.
  - else: cnt_n <= cnt_n+1.
  - A mismatch pulse shorter than FILTER_CNT cycles on s2_n leaves f_n unchanged and clears cnt_n.
  - FILTER_CNT=1: f_n follows s2_n with 1 cycle delay.
- Change pulse:
  - E_n = (mode != 00) && (sel_n != prev_n), combinational from flops.
  - High for exactly the first cycle of each new O_n value.
  - Mode 00: E_n = 0.
- Reset outputs:
  - modes 01/10/11: O_n = 0, E_n = 0 during and immediately after reset.
  - mode 00: O_n = I_n.
- Reset mid-filter: in-progress count is discarded; f_n returns to 0.
  - If I_n = 1 persists after reset, O_n in mode 11 rises at t0+1+FILTER_CNT, counted from the first post-reset sampling edge.
- ConfigBits change at run time:
  - Takes effect combinationally on the output select; no flop is disturbed.
  - If the newly selected value differs from prev_n, E_n pulses for one cycle.
  - Switching to mode 00 forces E_n low immediately.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset/bypass (all modes 00, UserRST=1): I=4'b1010 -> O=4'b1010, E=0. Switch to modes 01/10/11 under reset -> O=0, E=0.
- Latency (ch0..ch3 modes 00/01/10/11, FILTER_CNT=4): step all I from 0 to 1, sampled at edge t0 ->
  - O0 rises immediately.
  - O1 rises after t0.
  - O2 rises after t0+1.
  - O3 rises after t0+5.
  - E1/E2/E3 each high for exactly one cycle at their rise.
- Glitch rejection (mode 11, FILTER_CNT=4):
  - 3-cycle high pulse on I0 -> O0 stays 0, E0 stays 0, cnt returns to 0.
  - 4-cycle pulse -> O0 rises once at t0+5 and falls 4 cycles after s2 returns low; E0 pulses on both edges.
- Reset mid-operation (mode 11): hold I3=1 and assert UserRST 2 cycles after s2 goes high ->
  - O3 stays 0.
  - After release, O3 rises at first post-reset sampling edge +5.
- Runtime reconfig: ch1 with I1=1 held for 10 cycles, switch mode 00 -> 01 ->
  - O1 stays 1, E1 stays 0.
  - Then force r_1 != prev_1 by toggling I1 while switching to mode 10 -> E1 pulses for exactly one cycle.
- FILTER_CNT=1 build, mode 11: I2 toggles every 2 cycles -> O2 tracks I2 with a 2-edge delay, and E2 pulses on every change.
